imem_boot_loader: RTL and testbench

Boot-time controller for the instruction memory. It holds the core out of execution while a byte stream, from a UART receiver or testbench, is packed into 32-bit words and written into the instruction memory. It then releases the core and hands the memory address port to instruction fetch. It sits between the core's PC/fetch path and the write-capable instruction memory, owning the memory's address and write-enable.

---
 rtl/imem_boot_loader_pkg.sv | 22 ++
 rtl/imem_boot_loader_byte_packer.sv | 19 +
 rtl/imem_boot_loader.sv | 154 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int IMEM_DEPTH = 1024;
  localparam int LEN_WIDTH  = 16;
  localparam int WORD_SHIFT = 2;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
    return word_idx << WORD_SHIFT;
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Little-endian byte-to-word packer: newest byte enters the top, so after four
// shifts the first byte of the word sits in [7:0].
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_out <= '0;
    end else if (shift_en) begin
      word_out <= {byte_in, word_out[31:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a length-prefixed byte stream into instruction memory,
// then releases the core and hands the memory address port to fetch.
//
// state | meaning
// IDLE  | after reset, core held, waiting for load_en
// LEN0  | expecting low byte of word count
// LEN1  | expecting high byte of word count
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle write strobe of the packed word
// DONE  | load complete, core runs, fetch owns mem_addr
// ERR   | header exceeded memory depth, locked until reset
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int LEN_W = LEN_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] core_addr,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        core_run,
  output logic        load_done,
  output logic        load_err
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] n_len;
  logic [LEN_W-1:0] n_len_nxt;
  logic [LEN_W-1:0] widx;
  logic [LEN_W-1:0] widx_nxt;
  logic [LEN_W-1:0] len_hdr;
  logic [1:0]       bcnt;
  logic [1:0]       bcnt_nxt;
  logic             byte_ready_nxt;
  logic             load_done_nxt;
  logic             xfer;
  logic             shift_en;
  logic [31:0]      packed_word;

  assign xfer     = byte_valid && byte_ready;
  assign shift_en = xfer && (state == DATA);
  assign len_hdr  = LEN_W'({byte_data, n_len[7:0]});

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .byte_in  (byte_data),
    .word_out (packed_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      n_len      <= '0;
      widx       <= '0;
      bcnt       <= '0;
      byte_ready <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      n_len      <= n_len_nxt;
      widx       <= widx_nxt;
      bcnt       <= bcnt_nxt;
      byte_ready <= byte_ready_nxt;
      load_done  <= load_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    n_len_nxt = n_len;
    widx_nxt  = widx;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (load_en) state_nxt = LEN0;
      end
      LEN0: begin
        if (xfer) begin
          n_len_nxt = LEN_W'(byte_data);
          state_nxt = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          n_len_nxt = len_hdr;
          widx_nxt  = '0;
          bcnt_nxt  = '0;
          if (len_hdr == '0) begin
            state_nxt = DONE;
          end else if (32'(len_hdr) > 32'(DEPTH)) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          bcnt_nxt = bcnt + 2'd1;
          if (bcnt == 2'd3) state_nxt = WRITE;
        end
      end
      WRITE: begin
        widx_nxt = widx + LEN_W'(1);
        if (widx == n_len - LEN_W'(1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DATA;
        end
      end
      DONE: begin
        if (load_en) state_nxt = LEN0;
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered decodes: byte_ready follows the state being entered, and the
  // done pulse fires only on the edge that enters DONE.
  always_comb begin
    byte_ready_nxt = (state_nxt == LEN0) || (state_nxt == LEN1) || (state_nxt == DATA);
    load_done_nxt  = (state_nxt == DONE) && (state != DONE);
  end

  assign mem_we    = (state == WRITE);
  assign core_run  = (state == DONE);
  assign load_err  = (state == ERR);
  assign mem_wdata = packed_word;

  always_comb begin
    mem_addr = '0;
    if (core_run) begin
      mem_addr = core_addr;
    end else if ((state == DATA) || (state == WRITE)) begin
      mem_addr = word_to_byte_addr(32'(widx));
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader: expected memory writes are
// queued as words are streamed and popped by a monitor on every write strobe.
module tb_imem_boot_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] core_addr;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        core_run;
  logic        load_done;
  logic        load_err;

  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;
  wr_t         exp_q[$];
  logic [31:0] wq[$];
  logic        prev_we = 1'b0;
  wr_t         mon_e;

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .core_addr  (core_addr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .core_run   (core_run),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued expected write.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          failures++;
          $display("FAIL write_content actual=%0h:%0h expected=%0h:%0h",
                   mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
      check("ready_in_write", 32'(byte_ready), 32'd0);
      check("we_one_cycle", 32'(prev_we), 32'd0);
      check("core_run_in_write", 32'(core_run), 32'd0);
    end
    if (load_done === 1'b1) begin
      done_cnt++;
      check("done_with_run", 32'(core_run), 32'd1);
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  t;
    bit  sent;
    t    = 0;
    sent = 0;
    while (!sent) begin
      @(negedge clk);
      core_addr  = $urandom;
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = byte_valid ? b : 8'($urandom);
      if (byte_valid && byte_ready) begin
        sent = 1;
      end else if (++t > 100) begin
        check("byte_accept_timeout", 32'(t), 32'd0);
        byte_valid = 1'b0;
        sent       = 1;
      end
    end
    @(posedge clk);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_en    = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    check("start_core_run", 32'(core_run), 32'd0);
    check("start_mem_addr", mem_addr, 32'd0);
    check("start_byte_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Streams the words in wq; the model's expected writes are word i at byte address 4*i.
  task automatic do_load(input bit gaps);
    int          n;
    int          d0;
    logic [31:0] w;
    n  = wq.size();
    start_load();
    d0 = done_cnt;
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    if (n == 0) begin
      #1;
      check("n0_core_run", 32'(core_run), 32'd1);
      check("n0_load_done", 32'(load_done), 32'd1);
    end
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      exp_q.push_back('{addr: 32'(i * 4), data: w});
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps);
      if (i == n - 1) begin
        #1;
        check("last_we", 32'(mem_we), 32'd1);
        check("last_core_run_low", 32'(core_run), 32'd0);
        @(posedge clk);
        #1;
        check("last_we_fall", 32'(mem_we), 32'd0);
        check("done_core_run", 32'(core_run), 32'd1);
        check("done_pulse", 32'(load_done), 32'd1);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("done_pulse_low", 32'(load_done), 32'd0);
    check("run_after_load", 32'(core_run), 32'd1);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_core_run"}, 32'(core_run), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  initial begin
    rst        = 1'b1;
    load_en    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    core_addr  = 32'h1234_5678;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_hold_run", 32'(core_run), 32'd0);
    check("idle_hold_ready", 32'(byte_ready), 32'd0);

    wq.delete();
    wq.push_back(32'h0000_0013);
    wq.push_back(32'h0010_0093);
    do_load(1'b0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_addr = (i == 0) ? 32'h0000_0040 : $urandom;
      #1;
      check("fetch_mux", mem_addr, core_addr);
    end

    wq.delete();
    do_load(1'b0);

    fill_random(3);
    do_load(1'b1);

    for (int k = 0; k < 6; k++) begin
      fill_random($urandom_range(1, 8));
      do_load(1'($urandom_range(0, 1)));
    end

    fill_random(1024);
    do_load(1'b0);

    // Reset mid-load after one full word and two bytes of the next.
    fill_random(3);
    start_load();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back('{addr: 32'd0, data: wq[0]});
    for (int b = 0; b < 4; b++) send_byte(wq[0][8*b +: 8], 1'b0);
    send_byte(wq[1][7:0], 1'b0);
    send_byte(wq[1][15:8], 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle_run", 32'(core_run), 32'd0);
    fill_random(3);
    do_load(1'b1);

    // Oversized header locks into error until reset.
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    #1;
    check("err_flag", 32'(load_err), 32'd1);
    check("err_core_run", 32'(core_run), 32'd0);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    load_en    = 1'b1;
    repeat (5) @(negedge clk);
    load_en = 1'b0;
    check("err_sticky", 32'(load_err), 32'd1);
    check("err_byte_ready", 32'(byte_ready), 32'd0);
    check("err_run_low", 32'(core_run), 32'd0);
    check("err_mem_addr", mem_addr, 32'd0);
    byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("err_rst");
    @(negedge clk);
    rst = 1'b1;
    fill_random(2);
    do_load(1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
